// File: rtl/mult_seq_ctrl.sv
// Unsigned WIDTH x WIDTH multiplier. It reuses one 4x4 Wallace multiplier for every
// nibble pair, computes one shifted partial product per clock, and accumulates the results.

module multiplier4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s1, c1, s2, c2;

  // Two carry-save layers reduce the four rows to two, then one carry-propagate add.
  // The true product fits in 8 bits, so any carry dropped at bit 8 cannot change it.
  always_comb begin
    pp0 = {4'b0000, a & {4{b[0]}}};
    pp1 = {3'b000, a & {4{b[1]}}, 1'b0};
    pp2 = {2'b00, a & {4{b[2]}}, 2'b00};
    pp3 = {1'b0, a & {4{b[3]}}, 3'b000};
    s1  = pp0 ^ pp1 ^ pp2;
    c1  = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
    s2  = s1 ^ c1 ^ pp3;
    c2  = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
    p   = s2 + c2;
  end

endmodule

module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N     = WIDTH / 4;
  localparam int STEPS = N * N;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   ra, rb;
  logic [KW-1:0]      k;
  logic [IW-1:0]      ci, cj;
  logic [2*WIDTH-1:0] acc;

  logic [3:0]         nib_a, nib_b;
  logic [7:0]         pp8;
  logic [IW:0]        nib_sum;
  logic [IW+2:0]      shamt;
  logic [2*WIDTH-1:0] pp_ext, pp_shifted, acc_next;
  logic               last_step, accept;

  // ci and cj track k mod N and k div N. This avoids a divider in the operand-select path.
  always_comb begin
    nib_a      = ra[{ci, 2'b00} +: 4];
    nib_b      = rb[{cj, 2'b00} +: 4];
    nib_sum    = {1'b0, ci} + {1'b0, cj};
    shamt      = {nib_sum, 2'b00};
    pp_ext     = '0;
    pp_ext[7:0] = pp8;
    pp_shifted = pp_ext << shamt;
    acc_next   = acc + pp_shifted;
    last_step  = (k == KW'(STEPS - 1));
    accept     = start && ((state == IDLE) || (state == DONE));
  end

  multiplier4_bit u_mul (
    .a (nib_a),
    .b (nib_b),
    .p (pp8)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      k       <= '0;
      ci      <= '0;
      cj      <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        ra  <= a;
        rb  <= b;
        k   <= '0;
        ci  <= '0;
        cj  <= '0;
        acc <= '0;
      end else if (state == RUN) begin
        acc <= acc_next;
        k   <= k + 1'b1;
        if (ci == IW'(N - 1)) begin
          ci <= '0;
          cj <= cj + 1'b1;
        end else begin
          ci <= ci + 1'b1;
        end
        // The final partial product goes straight into product, so product is valid during DONE.
        if (last_step) product <= acc_next;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with one WIDTH=8 and one WIDTH=16 instance.
// A queue scoreboard holds the expected products and checks each one on its done pulse.

module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] product8;
  logic [31:0] product16;

  int checks = 0;
  int errors = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  logic [15:0] exp8;
  logic [31:0] exp16;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expv;
  } vec_t;

  vec_t vecs[8];

  mult_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  mult_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .start   (start16),
    .a       (a16),
    .b       (b16),
    .busy    (busy16),
    .done    (done16),
    .product (product16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The bench drives inputs at the falling edge, so the DUT samples them on the next rising edge.
  task automatic applyStimulus(input bit wide, input logic [15:0] av, input logic [15:0] bv,
                               input logic [31:0] expv);
    if (wide) begin
      a16 = av; b16 = bv; start16 = 1'b1;
      q16.push_back(expv);
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
      q8.push_back(expv[15:0]);
    end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) checkOutput("unexpected_done8", {31'b0, done8}, 32'd0);
      else begin
        exp8 = q8.pop_front();
        checkOutput("product8", {16'b0, product8}, {16'b0, exp8});
      end
    end
    if (!rst && done16) begin
      if (q16.size() == 0) checkOutput("unexpected_done16", {31'b0, done16}, 32'd0);
      else begin
        exp16 = q16.pop_front();
        checkOutput("product16", product16, exp16);
      end
    end
  end

  initial begin
    int dones;
    int issued;
    int completed;
    int cyc;
    logic [15:0] ra16, rb16;

    vecs[0] = '{8'd2,   8'd5,   16'd10};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd0,   8'd0,   16'd0};
    vecs[3] = '{8'hA7,  8'h3C,  16'd10020};
    vecs[4] = '{8'h12,  8'h34,  16'd936};
    vecs[5] = '{8'h0F,  8'hF0,  16'd3600};
    vecs[6] = '{8'hF0,  8'h0F,  16'd3600};
    vecs[7] = '{8'd1,   8'd255, 16'd255};

    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy8", {31'b0, busy8}, 32'd0);
    checkOutput("reset_done8", {31'b0, done8}, 32'd0);
    checkOutput("reset_product8", {16'b0, product8}, 32'd0);
    checkOutput("reset_product16", product16, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: a single-cycle start, busy in cycles 1-4, done pulse in cycle 5
    for (int v = 0; v < 8; v++) begin
      applyStimulus(1'b0, {8'h00, vecs[v].a}, {8'h00, vecs[v].b}, {16'h0000, vecs[v].expv});
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      for (int c = 1; c <= 4; c++) begin
        checkOutput($sformatf("busy_v%0d_c%0d", v, c), {30'b0, busy8, done8}, 32'd2);
        @(negedge clk);
      end
      checkOutput($sformatf("done_v%0d", v), {30'b0, busy8, done8}, 32'd1);
      @(negedge clk);
      checkOutput($sformatf("idle_v%0d", v), {30'b0, busy8, done8}, 32'd0);
      if (v == 0) begin
        repeat (9) @(negedge clk);
        checkOutput("product_hold", {16'b0, product8}, 32'd10);
      end
    end

    // Hold start high for back-to-back operations, and present new operands in the DONE cycle
    a8 = 8'd7; b8 = 8'd14; start8 = 1'b1; q8.push_back(16'd98);
    dones = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (done8) dones++;
      if (c <= 4) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      if (c == 5) begin
        checkOutput("b2b_done_c5", {31'b0, done8}, 32'd1);
        a8 = 8'd15; b8 = 8'd15; q8.push_back(16'd225);
      end
      if (c == 6) start8 = 1'b0;
      if (c == 10) checkOutput("b2b_done_c10", {31'b0, done8}, 32'd1);
    end
    checkOutput("b2b_done_count", dones, 32'd2);

    // Reset in the middle of RUN discards the operation
    a8 = 8'hFF; b8 = 8'h02; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrun_rst_busy", {31'b0, busy8}, 32'd0);
    checkOutput("midrun_rst_done", {31'b0, done8}, 32'd0);
    checkOutput("midrun_rst_product", {16'b0, product8}, 32'd0);
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8) dones++;
    end
    checkOutput("midrun_no_done", dones, 32'd0);
    applyStimulus(1'b0, 16'd3, 16'd3, 32'd9);
    repeat (4) @(negedge clk);
    checkOutput("after_rst_done", {31'b0, done8}, 32'd1);
    @(negedge clk);

    // Random back-to-back stream: one result every 5 cycles
    a8 = 8'($urandom); b8 = 8'($urandom);
    q8.push_back(16'(a8) * 16'(b8));
    start8 = 1'b1;
    issued = 1; completed = 0; cyc = 0;
    while (completed < 200 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        completed++;
        if (issued < 200) begin
          a8 = 8'($urandom); b8 = 8'($urandom);
          q8.push_back(16'(a8) * 16'(b8));
          issued++;
        end else begin
          start8 = 1'b0;
        end
      end
    end
    checkOutput("random_completed", completed, 32'd200);
    checkOutput("random_cycles", cyc, 32'd1000);
    @(negedge clk);

    // WIDTH=16: 16 steps, with done in cycle 17
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    for (int c = 1; c <= 16; c++) begin
      if (c == 1 || c == 16) checkOutput($sformatf("busy16_c%0d", c), {30'b0, busy16, done16}, 32'd2);
      @(negedge clk);
    end
    checkOutput("done16_c17", {30'b0, busy16, done16}, 32'd1);
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      if (v == 0) begin
        ra16 = 16'h1234; rb16 = 16'h0010;
      end else begin
        ra16 = 16'($urandom); rb16 = 16'($urandom);
      end
      applyStimulus(1'b1, ra16, rb16, 32'(ra16) * 32'(rb16));
      cyc = 0;
      while (!done16 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput($sformatf("wait16_v%0d", v), cyc, 32'd16);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue8_empty", q8.size(), 32'd0);
    checkOutput("queue16_empty", q16.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
